spi_rx_wide: RTL and testbench

//  Serial-to-parallel receiver. Parametrised successor of the 8-bit bit-stream receiver.
//  - Generic word width.
//  - Selectable bit order.
//  - Per-bit valid qualifier.
//  - Synchronous flush.
//  - Small output FIFO for the downstream consumer, with overflow flag.

---
 rtl/spi_rx_pkg.sv | 17 +
 rtl/spi_rx_fifo.sv | 70 +++++++
 rtl/spi_rx_wide.sv | 98 +++++++++
 tb/tb_spi_rx_wide.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared constants and width helpers for the wide serial receiver.
package spi_rx_pkg;

    localparam int BIT_LSB_FIRST = 0;
    localparam int BIT_MSB_FIRST = 1;

    // Index width for a counter/pointer over n positions (at least 1 bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Occupancy width able to hold 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word fall-through FIFO; head reads as 0 while empty.
module spi_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [lvl_w(DEPTH)-1:0]    lvl
);

    localparam int AW = idx_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]               lvl_q, lvl_d;
    logic                        push_ok, pop_ok;

    assign empty = (lvl_q == '0);
    assign full  = (lvl_q == LW'(DEPTH));
    assign lvl   = lvl_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO only lands if a pop frees the head slot on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lvl_d    = lvl_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
        end
    end

endmodule

// File: rtl/spi_rx_wide.sv
// Serial-to-parallel receiver: assembles WIDTH qualified bits into a word,
// publishes it with a one-cycle strobe and queues it in a small FWFT FIFO.
module spi_rx_wide
    import spi_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = BIT_LSB_FIRST,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       bit_in,
    input  logic                       bit_vld,
    input  logic                       flush,
    output logic [WIDTH-1:0]           word,
    output logic                       word_vld,
    input  logic                       fifo_rd,
    output logic [WIDTH-1:0]           fifo_dout,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [lvl_w(DEPTH)-1:0]    fifo_lvl,
    output logic                       ovf
);

    localparam int CW = idx_w(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_vld_q, word_vld_d;
    logic             ovf_q, ovf_d;
    logic             accept, done;
    logic [CW-1:0]    pos;

    // flush outranks bit_vld, so a flushed cycle can never complete a word.
    assign accept = bit_vld && !flush;
    assign done   = accept && (cnt_q == CW'(WIDTH - 1));
    assign pos    = (MSB_FIRST == BIT_MSB_FIRST) ? (CW'(WIDTH - 1) - cnt_q) : cnt_q;

    always_comb begin
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        word_d     = word_q;
        word_vld_d = 1'b0;
        ovf_d      = ovf_q;
        if (flush) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (accept) begin
            sr_d[pos] = bit_in;
            if (done) begin
                word_d     = sr_d;
                word_vld_d = 1'b1;
                cnt_d      = '0;
                sr_d       = '0;
                if (fifo_full && !fifo_rd) ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q      <= '0;
            sr_q       <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign word     = word_q;
    assign word_vld = word_vld_q;
    assign ovf      = ovf_q;

    spi_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (done),
        .din   (word_d),
        .pop   (fifo_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .lvl   (fifo_lvl)
    );

endmodule

// File: tb/tb_spi_rx_wide.sv
// Three receivers (LSB/D4, MSB/D4, LSB/D2) share one stimulus stream and are
// compared every cycle against a queue-based reference model.
module tb_spi_rx_wide;
    import spi_rx_pkg::*;

    logic clk = 1'b0;
    logic rst_b, bit_in, bit_vld, flush, fifo_rd;

    logic [7:0] w0, w1, w2, d0, d1, d2;
    logic       v0, v1, v2, e0, e1, e2, f0, f1, f2, o0, o1, o2;
    logic [2:0] l0, l1;
    logic [1:0] l2;

    always #5 clk = ~clk;

    spi_rx_wide #(.WIDTH(8), .MSB_FIRST(BIT_LSB_FIRST), .DEPTH(4)) u0 (
        .clk(clk), .rst_b(rst_b), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
        .word(w0), .word_vld(v0), .fifo_rd(fifo_rd), .fifo_dout(d0),
        .fifo_empty(e0), .fifo_full(f0), .fifo_lvl(l0), .ovf(o0));
    spi_rx_wide #(.WIDTH(8), .MSB_FIRST(BIT_MSB_FIRST), .DEPTH(4)) u1 (
        .clk(clk), .rst_b(rst_b), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
        .word(w1), .word_vld(v1), .fifo_rd(fifo_rd), .fifo_dout(d1),
        .fifo_empty(e1), .fifo_full(f1), .fifo_lvl(l1), .ovf(o1));
    spi_rx_wide #(.WIDTH(8), .MSB_FIRST(BIT_LSB_FIRST), .DEPTH(2)) u2 (
        .clk(clk), .rst_b(rst_b), .bit_in(bit_in), .bit_vld(bit_vld), .flush(flush),
        .word(w2), .word_vld(v2), .fifo_rd(fifo_rd), .fifo_dout(d2),
        .fifo_empty(e2), .fifo_full(f2), .fifo_lvl(l2), .ovf(o2));

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    bit pb[$];
    int fq[3][$];
    int word_m[3];
    bit vld_m[3];
    bit ovf_m[3];
    int dep[3] = '{4, 4, 2};
    bit msb[3] = '{1'b0, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pb.delete();
        for (int i = 0; i < 3; i++) begin
            fq[i].delete();
            word_m[i] = 0;
            vld_m[i]  = 1'b0;
            ovf_m[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic b, input logic v, input logic f, input logic rd);
        bit done;
        int wl, wm, w;
        bit popped, was_full;
        done = 1'b0;
        wl = 0;
        wm = 0;
        if (f) pb.delete();
        else if (v) begin
            pb.push_back(b);
            if (pb.size() == 8) begin
                foreach (pb[k]) begin
                    wl += int'(pb[k]) << k;
                    wm += int'(pb[k]) << (7 - k);
                end
                done = 1'b1;
                pb.delete();
            end
        end
        for (int i = 0; i < 3; i++) begin
            w        = msb[i] ? wm : wl;
            popped   = rd && (fq[i].size() > 0);
            was_full = (fq[i].size() == dep[i]);
            if (popped) void'(fq[i].pop_front());
            if (done) begin
                word_m[i] = w;
                if (was_full && !popped) ovf_m[i] = 1'b1;
                else fq[i].push_back(w);
            end
            vld_m[i] = done;
        end
    endtask

    task automatic chk_inst(input int i, input logic [7:0] w, input logic wv, input logic [7:0] d,
                            input logic e, input logic f, input logic [2:0] l, input logic o);
        int sz;
        sz = fq[i].size();
        chk($sformatf("word%0d", i), 32'(w), 32'(word_m[i]));
        chk($sformatf("word_vld%0d", i), 32'(wv), 32'(vld_m[i]));
        chk($sformatf("dout%0d", i), 32'(d), (sz > 0) ? 32'(fq[i][0]) : 32'd0);
        chk($sformatf("empty%0d", i), 32'(e), 32'(sz == 0));
        chk($sformatf("full%0d", i), 32'(f), 32'(sz == dep[i]));
        chk($sformatf("lvl%0d", i), 32'(l), 32'(sz));
        chk($sformatf("ovf%0d", i), 32'(o), 32'(ovf_m[i]));
    endtask

    task automatic check_all();
        chk_inst(0, w0, v0, d0, e0, f0, l0, o0);
        chk_inst(1, w1, v1, d1, e1, f1, l1, o1);
        chk_inst(2, w2, v2, d2, e2, f2, {1'b0, l2}, o2);
    endtask

    task automatic cycle(input logic b, input logic v, input logic f, input logic rd);
        bit_in  = b;
        bit_vld = v;
        flush   = f;
        fifo_rd = rd;
        @(posedge clk);
        model_step(b, v, f, rd);
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [7:0] val, input logic rd_last);
        for (int k = 0; k < 8; k++) cycle(val[k], 1'b1, 1'b0, (k == 7) ? rd_last : 1'b0);
    endtask

    task automatic do_reset();
        bit_in = 0; bit_vld = 0; flush = 0; fifo_rd = 0;
        rst_b = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    logic [7:0] t1a, t1b, t2, t3;

    initial begin
        t1a = 8'b0101_0011;   // stream 1,1,0,0,1,0,1,0 in LSB-first order
        t1b = 8'b1111_1100;
        t2  = 8'b1110_0101;
        do_reset();
        chk("rst_word", 32'(w0), 32'd0);
        chk("rst_empty", 32'(e0), 32'd1);

        // LSB-first words; MSB instance sees the same stream
        for (int k = 0; k < 7; k++) cycle(t1a[k], 1'b1, 1'b0, 1'b0);
        chk("t1_pre", 32'(w0), 32'd0);
        cycle(t1a[7], 1'b1, 1'b0, 1'b0);
        chk("t1_w53", 32'(w0), 32'h53);
        chk("t1_vld", 32'(v0), 32'd1);
        chk("t3_wCA", 32'(w1), 32'hCA);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_vld_drop", 32'(v0), 32'd0);
        send_word(t1b, 1'b0);
        chk("t1_wFC", 32'(w0), 32'hFC);

        // partial word then flush
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0);
            chk("t2_hold", 32'(w0), 32'hFC);
            chk("t2_novld", 32'(v0), 32'd0);
        end
        send_word(t2, 1'b0);
        chk("t2_wE5", 32'(w0), 32'hE5);

        // MSB-first with gaps between accepted bits
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(t1a[k], 1'b1, 1'b0, 1'b0);
            if (k < 7) begin
                for (int g = 0; g < (k % 3); g++) cycle(~t1a[k], 1'b0, 1'b0, 1'b0);
                chk("t3_gap_novld", 32'(v1), 32'd0);
            end
        end
        chk("t3_gap_wCA", 32'(w1), 32'hCA);
        chk("t3_gap_vld", 32'(v1), 32'd1);

        // DEPTH=2 overflow and drain
        do_reset();
        send_word(t1a, 1'b0);
        send_word(t1b, 1'b0);
        send_word(t2, 1'b0);
        chk("t4_full", 32'(f2), 32'd1);
        chk("t4_ovf", 32'(o2), 32'd1);
        chk("t4_head", 32'(d2), 32'h53);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_head2", 32'(d2), 32'hFC);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_empty", 32'(e2), 32'd1);
        chk("t4_dout0", 32'(d2), 32'd0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_lvl0", 32'(l2), 32'd0);
        chk("t4_ovf_sticky", 32'(o2), 32'd1);

        // full FIFO with completion coincident with a pop
        do_reset();
        t3 = 8'h3C;
        send_word(t1a, 1'b0);
        send_word(t1b, 1'b0);
        send_word(t2, 1'b0);
        send_word(t3, 1'b0);
        chk("t5_full", 32'(f0), 32'd1);
        send_word(8'hA7, 1'b1);
        chk("t5_lvl", 32'(l0), 32'd4);
        chk("t5_ovf", 32'(o0), 32'd0);
        chk("t5_head", 32'(d0), 32'hFC);

        // async reset mid-word
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_b = 1'b0;
        #1;
        model_reset();
        chk("t6_word0", 32'(w0), 32'd0);
        chk("t6_lvl0", 32'(l0), 32'd0);
        chk("t6_empty", 32'(e0), 32'd1);
        check_all();
        @(negedge clk);
        rst_b = 1'b1;
        send_word(8'h81, 1'b0);
        chk("t6_fresh", 32'(w0), 32'h81);
        chk("t6_fresh_msb", 32'(w1), 32'h81);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 75),
                  ($urandom_range(0, 99) < 4),
                  ($urandom_range(0, 99) < 30));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
